// File: rtl/fpu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// pa_fpu -- shared FPU types.
//   e_fpu_operation : 4-bit opcode; 0x0..op_exp are executable, the rest are
//                     rejected by the arbiter with an error response.
//   e_fpu_arb_state : states of the two-requester FPU arbiter.
//   is_legal_op()   : true when an opcode may be sent to the FPU core.
// -----------------------------------------------------------------------------
package pa_fpu;

   typedef enum logic [3:0] {
      op_add  = 4'h0,
      op_sub  = 4'h1,
      op_mul  = 4'h2,
      op_div  = 4'h3,
      op_sqrt = 4'h4,
      op_min  = 4'h5,
      op_max  = 4'h6,
      op_cmp  = 4'h7,
      op_cvt  = 4'h8,
      op_exp  = 4'h9   // last opcode the FPU core executes
   } e_fpu_operation;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_WAIT,
      ARB_RESP
   } e_fpu_arb_state;

   function automatic logic is_legal_op(input e_fpu_operation op);
      return op <= op_exp;
   endfunction

endpackage

// File: rtl/fpu_arbiter_if.sv
// -----------------------------------------------------------------------------
// fpu_arbiter_if -- requester and FPU-core signals of the FPU arbiter.
//   Requester side : req_valid/req_ready/req_op/req_a/req_b (per requester),
//                    resp_valid/resp_ready (per requester), resp_result/resp_err
//                    (shared payload).
//   FPU side       : fpu_start/fpu_abort/fpu_op/fpu_a/fpu_b (command),
//                    fpu_done/fpu_result (completion).
//   master : the environment (requesters plus FPU core).
//   slave  : the arbiter.
// -----------------------------------------------------------------------------
interface fpu_arbiter_if;
   import pa_fpu::*;

   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   e_fpu_operation    req_op [2];
   logic [1:0][31:0]  req_a;
   logic [1:0][31:0]  req_b;

   logic [1:0]        resp_valid;
   logic [1:0]        resp_ready;
   logic [31:0]       resp_result;
   logic              resp_err;

   logic              fpu_start;
   logic              fpu_abort;
   e_fpu_operation    fpu_op;
   logic [31:0]       fpu_a;
   logic [31:0]       fpu_b;
   logic              fpu_done;
   logic [31:0]       fpu_result;

   modport master (
      output req_valid, req_op, req_a, req_b, resp_ready, fpu_done, fpu_result,
      input  req_ready, resp_valid, resp_result, resp_err,
             fpu_start, fpu_abort, fpu_op, fpu_a, fpu_b
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, resp_ready, fpu_done, fpu_result,
      output req_ready, resp_valid, resp_result, resp_err,
             fpu_start, fpu_abort, fpu_op, fpu_a, fpu_b
   );

endinterface

// File: rtl/fpu_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// fpu_rr_arb2 -- two-way round-robin grant, purely combinational.
//   req : request bits
//   ptr : preferred requester when both request
//   gnt : one-hot grant (all zero when nobody requests)
// -----------------------------------------------------------------------------
module fpu_rr_arb2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] gnt
);

   // A requester wins if it is alone, or if both request and it is preferred.
   assign gnt[0] = req[0] & (~req[1] | ~ptr);
   assign gnt[1] = req[1] & (~req[0] |  ptr);

endmodule

// File: rtl/fpu_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_arbiter -- shares one FPU core between two requesters.
//   clk, rst_n : rising-edge clock, synchronous active-low reset
//   bus        : fpu_arbiter_if.slave (requester command/response channels and
//                the FPU core command/completion channels)
// One operation is in flight at a time. Illegal opcodes are answered directly
// with an error; legal ones are started on the core, and an operation whose
// fpu_done does not arrive within TIMEOUT_CYCLES wait cycles is aborted and
// answered with an error.
// -----------------------------------------------------------------------------
module fpu_arbiter
   import pa_fpu::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic          clk,
   input  logic          rst_n,
   fpu_arbiter_if.slave  bus
);

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   e_fpu_arb_state  state, state_nxt;
   logic            ptr;
   logic            owner;
   e_fpu_operation  op_q;
   logic [31:0]     a_q, b_q, result_q;
   logic            err_q;
   logic [15:0]     cnt;

   logic [1:0]      gnt;
   logic            sel;
   e_fpu_operation  op_sel;
   logic            accept;
   logic            resp_hs;
   logic            timeout_hit;

   fpu_rr_arb2 u_rr (
      .req (bus.req_valid),
      .ptr (ptr),
      .gnt (gnt)
   );

   assign sel     = gnt[1];
   assign op_sel  = bus.req_op[sel];
   assign accept  = (state == ARB_IDLE) && (|gnt);
   assign resp_hs = (state == ARB_RESP) && bus.resp_ready[owner];
   // A completion in the last wait cycle beats the timeout.
   assign timeout_hit = (state == ARB_WAIT) && !bus.fpu_done && (cnt == CNT_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ARB_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first, so no path
   // through the case leaves it unassigned and infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         ARB_IDLE:  if (accept) state_nxt = is_legal_op(op_sel) ? ARB_ISSUE : ARB_RESP;
         ARB_ISSUE: state_nxt = ARB_WAIT;
         ARB_WAIT:  if (bus.fpu_done || timeout_hit) state_nxt = ARB_RESP;
         ARB_RESP:  if (resp_hs) state_nxt = ARB_IDLE;
         default:   state_nxt = ARB_IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready  = '0;
      bus.resp_valid = '0;
      bus.fpu_start  = 1'b0;
      bus.fpu_abort  = 1'b0;
      case (state)
         ARB_IDLE:  bus.req_ready = gnt;
         ARB_ISSUE: bus.fpu_start = 1'b1;
         ARB_WAIT:  bus.fpu_abort = timeout_hit;
         ARB_RESP:  bus.resp_valid[owner] = 1'b1;
         default:   ;
      endcase
   end

   assign bus.fpu_op      = op_q;
   assign bus.fpu_a       = a_q;
   assign bus.fpu_b       = b_q;
   assign bus.resp_result = result_q;
   assign bus.resp_err    = err_q;

   // Command/response registers. They only change on accept, completion or
   // timeout, which keeps the FPU command and the response payload stable
   // for as long as they are being presented.
   // NOTE: the payload registers are plain flops, not a memory, so they take
   // the reset value and the outputs they drive are defined straight after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr      <= 1'b0;
         owner    <= 1'b0;
         op_q     <= op_add;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         cnt      <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (accept) begin
                  owner <= sel;
                  op_q  <= op_sel;
                  a_q   <= bus.req_a[sel];
                  b_q   <= bus.req_b[sel];
                  if (!is_legal_op(op_sel)) begin
                     result_q <= '0;
                     err_q    <= 1'b1;
                  end
               end
            end
            ARB_ISSUE: cnt <= '0;
            ARB_WAIT: begin
               if (bus.fpu_done) begin
                  result_q <= bus.fpu_result;
                  err_q    <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  result_q <= '0;
                  err_q    <= 1'b1;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            ARB_RESP: if (resp_hs) ptr <= ~owner;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fpu_arbiter -- self-checking bench for fpu_arbiter (TIMEOUT_CYCLES = 8).
// Inputs are driven 1 ns after the rising edge; outputs are compared on the
// falling edge against a timestamp-based transaction model.
// -----------------------------------------------------------------------------
module tb_fpu_arbiter;
   import pa_fpu::*;

   localparam int TB_TIMEOUT = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fpu_arbiter_if bus ();

   fpu_arbiter #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   bit cmp_en = 1'b0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- FPU core model ----------------
   int          fpu_lat = 1;      // 0: never completes
   bit          fpu_noise = 1'b0; // spurious done pulses
   bit          fpu_fixed = 1'b0;
   logic [31:0] fpu_res_cfg = '0;
   int          countdown = 0;
   bit          start_seen, rst_seen;

   always @(negedge clk) begin
      start_seen = bus.fpu_start;
      rst_seen   = rst_n;
   end

   always @(posedge clk) begin
      #1;
      bus.fpu_done = 1'b0;
      if (!rst_seen) begin
         countdown = 0;
      end else begin
         if (start_seen) countdown = fpu_lat;
         if (countdown > 0) begin
            countdown--;
            if (countdown == 0) bus.fpu_done = 1'b1;
         end
      end
      if (fpu_noise && $urandom_range(15) == 0) bus.fpu_done = 1'b1;
      bus.fpu_result = fpu_fixed ? fpu_res_cfg : $urandom;
   end

   // ---------------- reference model + compare ----------------
   bit          m_busy = 1'b0;
   int          m_pref = 0, m_own = 0, m_start = -1, m_resp = -1;
   logic [3:0]  m_op;
   logic [31:0] m_a, m_b, m_res;
   logic        m_err;

   int start_cnt = 0, abort_cnt = 0, resp_cnt = 0, last_start = 0, last_abort = 0;
   int acc_q[$];

   function automatic int winner(input logic [1:0] v, input int pref);
      if (v[pref])     return pref;
      if (v[1 - pref]) return 1 - pref;
      return -1;
   endfunction

   always @(negedge clk) begin
      if (cmp_en) begin
         int   w;
         bit   waiting, resp_on;
         logic [1:0] exp_ready, exp_rv;
         logic exp_start, exp_abort;

         w         = winner(bus.req_valid, m_pref);
         exp_ready = (!m_busy && w >= 0) ? 2'(1 << w) : 2'b00;
         exp_start = m_busy && (m_start == cyc);
         waiting   = m_busy && m_start >= 0 && cyc > m_start && m_resp < 0;
         exp_abort = waiting && !bus.fpu_done && (cyc - m_start == TB_TIMEOUT);
         resp_on   = m_busy && m_resp >= 0 && cyc >= m_resp;
         exp_rv    = resp_on ? 2'(1 << m_own) : 2'b00;

         check("req_ready",  32'(bus.req_ready),  32'(exp_ready));
         check("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
         check("fpu_start",  32'(bus.fpu_start),  32'(exp_start));
         check("fpu_abort",  32'(bus.fpu_abort),  32'(exp_abort));
         if (resp_on) begin
            check("resp_result", bus.resp_result, m_res);
            check("resp_err",    32'(bus.resp_err), 32'(m_err));
         end
         if (m_busy && m_start >= 0 && cyc >= m_start && m_resp < 0) begin
            check("fpu_op", 32'(bus.fpu_op), 32'(m_op));
            check("fpu_a",  bus.fpu_a, m_a);
            check("fpu_b",  bus.fpu_b, m_b);
         end

         // observation counters for the directed scenarios
         if (bus.fpu_start) begin start_cnt++; last_start = cyc; end
         if (bus.fpu_abort) begin abort_cnt++; last_abort = cyc; end
         if (bus.resp_valid != 0) resp_cnt++;
         if (rst_n && (bus.req_valid & bus.req_ready) != 0) acc_q.push_back(bus.req_ready[1] ? 1 : 0);

         // what the coming edge does
         if (!rst_n) begin
            m_busy = 1'b0;
            m_pref = 0;
         end else if (!m_busy) begin
            if (w >= 0) begin
               m_busy = 1'b1;
               m_own  = w;
               m_op   = 4'(bus.req_op[w]);
               m_a    = bus.req_a[w];
               m_b    = bus.req_b[w];
               if (m_op <= 4'd9) begin
                  m_start = cyc + 1;
                  m_resp  = -1;
               end else begin
                  m_start = -1;
                  m_resp  = cyc + 1;
                  m_res   = '0;
                  m_err   = 1'b1;
               end
            end
         end else if (waiting) begin
            if (bus.fpu_done) begin
               m_resp = cyc + 1; m_res = bus.fpu_result; m_err = 1'b0;
            end else if (cyc - m_start == TB_TIMEOUT) begin
               m_resp = cyc + 1; m_res = '0; m_err = 1'b1;
            end
         end else if (resp_on && bus.resp_ready[m_own]) begin
            m_busy = 1'b0;
            m_pref = 1 - m_own;
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.req_valid[r] = 1'b1;
      bus.req_op[r]    = e_fpu_operation'(op);
      bus.req_a[r]     = a;
      bus.req_b[r]     = b;
   endtask

   task automatic wait_ready(input int r, output int t);
      t = -1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.req_ready[r]) begin t = cyc; break; end
      end
      if (t < 0) check($sformatf("wait_ready%0d_timeout", r), 32'd0, 32'd1);
   endtask

   task automatic wait_resp(input int r, output int t);
      t = -1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.resp_valid[r]) begin t = cyc; break; end
      end
      if (t < 0) check($sformatf("wait_resp%0d_timeout", r), 32'd0, 32'd1);
   endtask

   // one transaction on requester r; valid drops right after accept
   task automatic run_txn(input int r, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int t_acc, output int t_resp);
      set_req(r, op, a, b);
      wait_ready(r, t_acc);
      drive_edge();
      bus.req_valid[r] = 1'b0;
      wait_resp(r, t_resp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t_acc, t_resp, s0, a0, r0;

      bus.req_valid  = '0;
      bus.req_op[0]  = op_add;
      bus.req_op[1]  = op_add;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.resp_ready = 2'b11;
      bus.fpu_done   = 1'b0;
      bus.fpu_result = '0;

      // ---- reset state ----
      rst_n = 1'b0;
      drive_edge();
      cmp_en = 1'b1;
      repeat (2) drive_edge();
      @(negedge clk);
      check("rst_req_ready",  32'(bus.req_ready),  32'd0);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_fpu_start",  32'(bus.fpu_start),  32'd0);
      check("rst_fpu_abort",  32'(bus.fpu_abort),  32'd0);
      drive_edge();
      rst_n = 1'b1;
      drive_edge();

      // ---- requester 0, op_add 1.0 + 2.0, core answers after 3 cycles ----
      fpu_fixed = 1'b1; fpu_res_cfg = 32'h4040_0000; fpu_lat = 3;
      run_txn(0, 4'h0, 32'h3F80_0000, 32'h4000_0000, t_acc, t_resp);
      check("add_latency", 32'(t_resp - t_acc), 32'd5);
      check("add_result",  bus.resp_result, 32'h4040_0000);
      check("add_err",     32'(bus.resp_err), 32'd0);
      repeat (2) drive_edge();

      // ---- illegal opcode on requester 1 ----
      s0 = start_cnt;
      run_txn(1, 4'hC, 32'h1111_1111, 32'h2222_2222, t_acc, t_resp);
      check("illegal_latency", 32'(t_resp - t_acc), 32'd1);
      check("illegal_result",  bus.resp_result, 32'd0);
      check("illegal_err",     32'(bus.resp_err), 32'd1);
      drive_edge();
      check("illegal_no_start", 32'(start_cnt - s0), 32'd0);
      repeat (2) drive_edge();

      // ---- core never answers -> timeout ----
      a0 = abort_cnt; fpu_lat = 0;
      run_txn(0, 4'h2, 32'hDEAD_BEEF, 32'h0BAD_F00D, t_acc, t_resp);
      check("timeout_abort_delay", 32'(last_abort - last_start), 32'd8);
      check("timeout_abort_count", 32'(abort_cnt - a0), 32'd1);
      check("timeout_result",      bus.resp_result, 32'd0);
      check("timeout_err",         32'(bus.resp_err), 32'd1);
      repeat (2) drive_edge();

      // ---- done coincides with expiry; owner stalls, non-owner ready ignored ----
      a0 = abort_cnt; fpu_lat = 8; fpu_res_cfg = 32'h1234_5678;
      bus.resp_ready = 2'b10;
      run_txn(0, 4'h3, 32'h4120_0000, 32'h4000_0000, t_acc, t_resp);
      for (int k = 0; k < 10; k++) begin
         drive_edge();
         @(negedge clk);
         check("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
         check("hold_result",     bus.resp_result, 32'h1234_5678);
         check("hold_err",        32'(bus.resp_err), 32'd0);
      end
      check("race_no_abort", 32'(abort_cnt - a0), 32'd0);
      drive_edge();
      bus.resp_ready = 2'b11;
      repeat (3) drive_edge();

      // ---- reset during the wait phase drops the operation ----
      fpu_lat = 0;
      set_req(0, 4'h1, 32'h5555_5555, 32'hAAAA_AAAA);
      wait_ready(0, t_acc);
      drive_edge();
      bus.req_valid[0] = 1'b0;
      repeat (3) drive_edge();
      r0 = resp_cnt; a0 = abort_cnt;
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("midrst_fpu_start",  32'(bus.fpu_start),  32'd0);
      check("midrst_fpu_abort",  32'(bus.fpu_abort),  32'd0);
      check("midrst_req_ready",  32'(bus.req_ready),  32'd0);
      drive_edge();
      rst_n = 1'b1;
      repeat (20) drive_edge();
      check("midrst_no_resp",  32'(resp_cnt - r0),  32'd0);
      check("midrst_no_abort", 32'(abort_cnt - a0), 32'd0);

      // ---- both requesters hold valid from reset -> grants alternate ----
      rst_n = 1'b0; fpu_lat = 2;
      set_req(0, 4'h0, 32'h0000_0001, 32'h0000_0002);
      set_req(1, 4'h5, 32'h0000_0003, 32'h0000_0004);
      repeat (2) drive_edge();
      acc_q.delete();
      rst_n = 1'b1;
      for (int k = 0; k < 100 && acc_q.size() < 4; k++) drive_edge();
      if (acc_q.size() < 4) check("rr_accept_timeout", 32'(acc_q.size()), 32'd4);
      else for (int k = 0; k < 4; k++) check($sformatf("rr_grant%0d", k), 32'(acc_q[k]), 32'(k % 2));
      bus.req_valid = '0;
      repeat (20) drive_edge();

      // ---- randomized traffic ----
      fpu_fixed = 1'b0; fpu_noise = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         drive_edge();
         for (int i = 0; i < 2; i++) begin
            bus.req_valid[i] = ($urandom_range(2) != 0);
            bus.req_op[i]    = e_fpu_operation'(4'($urandom_range(15)));
            bus.req_a[i]     = $urandom;
            bus.req_b[i]     = $urandom;
         end
         bus.resp_ready = 2'($urandom_range(3));
         fpu_lat        = $urandom_range(10);
         rst_n          = ($urandom_range(399) != 0);
      end

      // ---- drain ----
      drive_edge();
      rst_n = 1'b1; bus.req_valid = '0; bus.resp_ready = 2'b11;
      fpu_noise = 1'b0; fpu_lat = 1;
      repeat (40) drive_edge();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 256: the number of WAIT cycles without fpu_done before the operation is declared failed; legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst_n, input, 1: the reset, synchronous and active-low.
REQ-004 The block SHALL have port req_valid, input, 2: per-requester command valid.
REQ-005 The block SHALL have port req_ready, output, 2: per-requester command accept.
REQ-006 The block SHALL have port req_op, input, 2x4: per-requester opcode, typed e_fpu_operation.
REQ-007 The block SHALL have ports req_a and req_b, input, 2x32 each: per-requester operands.
REQ-008 The block SHALL have port resp_valid, output, 2: per-requester response valid.
REQ-009 The block SHALL have port resp_ready, input, 2: per-requester response accept.
REQ-010 The block SHALL have ports resp_result, output, 32, and resp_err, output, 1: the shared response payload, meaningful only when a resp_valid bit is high.
REQ-011 The block SHALL have ports fpu_start, output, 1; fpu_abort, output, 1; fpu_op, output, 4; fpu_a and fpu_b, output, 32 each: the command side to the FPU core.
REQ-012 The block SHALL have ports fpu_done, input, 1 (single-cycle pulse) and fpu_result, input, 32 (valid with fpu_done): the completion side from the FPU core.

Function
REQ-013 The block SHALL implement states ARB_IDLE, ARB_ISSUE, ARB_WAIT and ARB_RESP.
REQ-014 In ARB_IDLE the block SHALL grant one requester with req_valid high, choosing by a 1-bit round-robin pointer: the pointed requester wins a tie, otherwise the only one requesting.
REQ-015 req_ready SHALL be high only for the granted requester, only in ARB_IDLE, and SHALL be combinational from req_valid and the pointer.
REQ-016 On accept (valid and ready), the block SHALL register op, a, b and the owner index.
REQ-017 After accept, the next state SHALL be ARB_ISSUE if op is 0x0..0x9; for op 0xA..0xF it SHALL be ARB_RESP with resp_err=1, resp_result=0 and no fpu_start.
REQ-018 In ARB_ISSUE the block SHALL pulse fpu_start for exactly one cycle with the registered fpu_op, fpu_a and fpu_b, clear the timeout counter, and go to ARB_WAIT.
REQ-019 fpu_op, fpu_a and fpu_b SHALL hold stable from ARB_ISSUE until ARB_WAIT exits.
REQ-020 In ARB_WAIT, fpu_done SHALL capture fpu_result with resp_err=0 and go to ARB_RESP; fpu_done outside ARB_WAIT SHALL be ignored.
REQ-021 In ARB_WAIT the counter SHALL increment each cycle without fpu_done; when it reaches TIMEOUT_CYCLES-1 the block SHALL pulse fpu_abort for one cycle, set resp_err=1 and resp_result=0, and go to ARB_RESP.
REQ-022 If fpu_done and timeout expiry coincide, done SHALL win and fpu_abort SHALL NOT pulse.
REQ-023 In ARB_RESP, resp_valid[owner] SHALL be high, with result and err stable, until resp_ready[owner] is high.
REQ-024 On that handshake the block SHALL return to ARB_IDLE and set the pointer to the non-owner.
REQ-025 resp_ready of the non-owner SHALL be ignored.
REQ-026 Latency SHALL be: accept at cycle T; fpu_start at T+1; fpu_done at T+1+N, N>=1; resp_valid at T+2+N.
REQ-027 The earliest next accept SHALL be the cycle after the response handshake.
REQ-028 A requester SHALL be able to hold req_valid through the other requester's entire transaction without losing its request.

Reset
REQ-029 While rst_n is low at a clk edge: state = ARB_IDLE; pointer = 0; counter = 0; registered op/a/b/result = 0; resp_err = 0.
REQ-030 Reset outputs SHALL be: req_ready follows REQ-015 from reset state; resp_valid = 0; fpu_start = 0; fpu_abort = 0.
REQ-031 Reset mid-operation SHALL drop the transaction with no response and no fpu_abort pulse; the FPU core shares rst_n.

Structure
REQ-032 The e_fpu_operation enum and the new enum e_fpu_arb_state (the four states) SHALL live in shared package pa_fpu.
REQ-033 The last-legal-opcode constant (op_exp) SHALL also live in pa_fpu.
REQ-034 The round-robin grant logic SHALL be a sub-module, fpu_rr_arb2: 2 requests, pointer in, one-hot grant out.
REQ-035 The counter and the state machine SHALL stay in fpu_arbiter.

Verification
REQ-036 Requester 0 only, op_add, a=0x3F800000, b=0x40000000; FPU model returns done after 3 cycles with 0x40400000 -> resp_valid[0] 5 cycles after accept, result 0x40400000, err=0.
REQ-037 Both requesters hold valid from reset -> grants alternate 0,1,0,1 across four transactions; no requester is granted twice in a row while the other waits.
REQ-038 op=0xC on requester 1 -> resp_valid[1] on the cycle after accept, err=1, result=0; fpu_start never asserts.
REQ-039 TIMEOUT_CYCLES=8, FPU model never returns done -> fpu_abort pulses once 8 cycles after fpu_start; response has err=1, result=0.
REQ-040 fpu_done on the same cycle as timeout expiry -> err=0, result captured, no fpu_abort; hold resp_ready=0 for 10 cycles -> resp_valid and payload stay stable.
REQ-041 Assert rst_n=0 during ARB_WAIT -> on the next edge all outputs take reset values, and no resp_valid appears for the dropped operation.
